// File: rtl/ocp_lite_defs.sv
// Shared OCP-lite encodings for the 8-bit link fabric: command, response,
// fixed read-only addresses and the generic slave handshake state.
package ocp_lite_defs;

    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_WR   = 3'b001;
    localparam logic [2:0] MCMD_RD   = 3'b010;

    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_FAIL = 2'b10;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    localparam logic [7:0] ADDR_ID     = 8'hFE;
    localparam logic [7:0] ADDR_STATUS = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } slave_state_e;

endpackage

// File: rtl/ocp_slave_fsm.sv
// Reusable OCP-lite slave handshake: accept one command in IDLE, then hold a
// response in RESP until the master takes it with MRespAccept.
module ocp_slave_fsm (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid_i,
    input  logic resp_accept_i,
    output logic cmd_accept_o,
    output logic accept_fire_o,
    output logic release_fire_o,
    output logic state_o
);
    import ocp_lite_defs::*;

    slave_state_e state_q;
    slave_state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid_i)   state_d = ST_RESP;
            ST_RESP: if (resp_accept_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Accept depends on state alone, so there is no path from MCmd to SCmdAccept.
    always_comb begin
        cmd_accept_o   = (state_q == ST_IDLE);
        accept_fire_o  = (state_q == ST_IDLE) && cmd_valid_i;
        release_fire_o = (state_q == ST_RESP) && resp_accept_i;
        state_o        = (state_q == ST_RESP);
    end

endmodule

// File: rtl/ocp_reg_slave.sv
// OCP-lite register slave: NUM_REGS RW registers, ID at 0xFE, live status at 0xFF.
// Define OCP_REG_SLAVE_ERR_EN to answer error cases with ERR instead of DVA.
module ocp_reg_slave #(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [7:0]  RESET_VAL = 8'h00,
    parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              MCmd,
    input  logic [7:0]              MAddr,
    input  logic [7:0]              MData,
    output logic                    SCmdAccept,
    output logic [7:0]              SData,
    output logic [1:0]              SResp,
    input  logic                    MRespAccept,
    output logic [8*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]     wr_pulse,
    input  logic [7:0]              status_in,
    output logic                    busy
);
    import ocp_lite_defs::*;

    logic                  accept_fire;
    logic                  release_fire;
    logic                  state_resp;

    logic [8*NUM_REGS-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [1:0]            sresp_q, sresp_d;
    logic [7:0]            sdata_q, sdata_d;

    logic                  is_wr, is_rd, in_rw, is_id, is_st;
    logic                  wr_ok, rd_ok;
    logic [7:0]            rd_data;
    logic [1:0]            resp_code;

    ocp_slave_fsm u_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (MCmd != MCMD_IDLE),
        .resp_accept_i  (MRespAccept),
        .cmd_accept_o   (SCmdAccept),
        .accept_fire_o  (accept_fire),
        .release_fire_o (release_fire),
        .state_o        (state_resp)
    );

    always_comb begin
        is_wr = (MCmd == MCMD_WR);
        is_rd = (MCmd == MCMD_RD);
        in_rw = (32'(MAddr) < NUM_REGS);
        is_id = (MAddr == ADDR_ID);
        is_st = (MAddr == ADDR_STATUS);
        wr_ok = is_wr && in_rw;
        rd_ok = is_rd && (in_rw || is_id || is_st);
    end

    always_comb begin
        rd_data = 8'h00;
        if (rd_ok) begin
            if (is_id) begin
                rd_data = ID_VALUE;
            end else if (is_st) begin
                rd_data = status_in;
            end else begin
                for (int n = 0; n < int'(NUM_REGS); n++) begin
                    if (MAddr == 8'(n)) rd_data = regs_q[8*n +: 8];
                end
            end
        end
    end

`ifdef OCP_REG_SLAVE_ERR_EN
    always_comb resp_code = (wr_ok || rd_ok) ? SRESP_DVA : SRESP_ERR;
`else
    always_comb resp_code = SRESP_DVA;
`endif

    // Response registers load on the accept edge and clear on the release edge.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        sresp_d    = sresp_q;
        sdata_d    = sdata_q;
        if (accept_fire) begin
            sresp_d = resp_code;
            sdata_d = rd_data;
            for (int n = 0; n < int'(NUM_REGS); n++) begin
                if (wr_ok && (MAddr == 8'(n))) begin
                    regs_d[8*n +: 8] = MData;
                    wr_pulse_d[n]    = 1'b1;
                end
            end
        end else if (release_fire) begin
            sresp_d = SRESP_NULL;
            sdata_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= {NUM_REGS{RESET_VAL}};
            wr_pulse_q <= '0;
            sresp_q    <= SRESP_NULL;
            sdata_q    <= 8'h00;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            sresp_q    <= sresp_d;
            sdata_q    <= sdata_d;
        end
    end

    assign reg_q    = regs_q;
    assign wr_pulse = wr_pulse_q;
    assign SResp    = sresp_q;
    assign SData    = sdata_q;
    assign busy     = state_resp;

endmodule

// File: doc/ocp_reg_slave.md
# ocp_reg_slave

Generic responder for the 8-bit OCP-lite link fabric: it terminates one slave port of the link switch (the same MCmd/SCmdAccept/SResp/MRespAccept interface the switch drives toward linebuffer, clock & reset, and debugger). It decodes write and read commands into a small register file, and answers every accepted command with exactly one response. Clock & reset and debugger control registers sit behind this block.

## Interface
- NUM_REGS, 8: number of read/write registers at addresses 0x00..NUM_REGS-1 (1..64).
- RESET_VAL, 8'h00: reset value of every read/write register.
- ID_VALUE, 8'hA5: constant returned on reads of address 0xFE.
- clk  in  1  50 MHz link clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MCmd  in  3  command: 3'b000 IDLE, 3'b001 WR, 3'b010 RD; 3..7 are invalid.
- MAddr  in  8  register address.
- MData  in  8  write data.
- SCmdAccept  out  1  command accepted this cycle when high with MCmd != IDLE.
- SData  out  8  read data, valid while SResp != NULL.
- SResp  out  2  response: 2'b00 NULL, 2'b01 DVA, 2'b11 ERR.
- MRespAccept  in  1  master consumes the response this cycle.
- reg_q  out  8*NUM_REGS  register contents; register n occupies bits [8n+7:8n].
- wr_pulse  out  NUM_REGS  one-cycle strobe; bit n is high for the cycle after register n is written.
- status_in  in  8  live status, readable at 0xFF.
- busy  out  1  high while a response is pending (state RESP).

## Operation
- FSM has two states. IDLE: SCmdAccept=1, SResp=NULL. RESP: SCmdAccept=0, SResp/SData are held stable.
- Accept happens on an edge where state=IDLE and MCmd!=IDLE. On that edge:
  - WR to a valid RW address: the register is updated from MData, and the matching wr_pulse bit is set for the next cycle only.
  - RD: SData is captured from the register, ID_VALUE, or status_in (sampled on the accept edge).
  - Response code is computed and the FSM goes to RESP.
- RESP with MRespAccept=1: on that edge go to IDLE, SResp goes to NULL, and SData goes to 8'h00. RESP with MRespAccept=0: hold.
- Address map: 0x00..NUM_REGS-1 are RW. 0xFE is RO (ID_VALUE). 0xFF is RO (status_in). Everything else is unmapped.
- Error cases: WR to 0xFE/0xFF, any access to an unmapped address, and invalid MCmd. See Configuration for the response these produce. None of them changes any register, and none pulses wr_pulse.
- WR response: DVA with SData=8'h00.
- MCmd is ignored while in RESP; the master must hold the command until accepted.

## Timing
- Reset values: SCmdAccept=1, SResp=NULL, SData=8'h00, busy=0, wr_pulse=0, every register=RESET_VAL, state=IDLE.
- Response latency: SResp is valid the cycle after the accept edge.
- Throughput: at most one transaction every 2 cycles (accept, then response consumed with MRespAccept=1 in the first RESP cycle).
- SCmdAccept is a function of state only. It has no combinational path from MCmd.
- SResp, SData, busy, and wr_pulse are all registered.
- Reset asserted mid-transaction: return to IDLE immediately, drop any pending response, and restore registers to RESET_VAL.
- MRespAccept while in IDLE has no effect.

## Configuration
- OCP_REG_SLAVE_ERR_EN defined: the error cases return SResp=ERR, SData=8'h00.
- Undefined: the error cases return DVA, SData=8'h00. The no-side-effect rule still applies, and ERR never appears.

## Structure
- Shared package/include ocp_lite_defs holds the MCmd encodings (IDLE/WR/RD), the SResp encodings (NULL/DVA/FAIL/ERR), and the address constants for ID (0xFE) and status (0xFF). The link switch uses the same file.
- Sub-module ocp_slave_fsm contains the IDLE/RESP handshake: accept, hold, and release on MRespAccept. It is reusable for other slaves.
- The register file and address decode live in ocp_reg_slave.

## Test plan
- Reset, then WR addr 0x03 data 0x5C → accepted on the first cycle; next cycle SResp=DVA, busy=1, wr_pulse[3]=1 for exactly one cycle, reg_q[31:24]=0x5C.
- RD 0x03 with MRespAccept held low for 4 cycles → SResp=DVA, SData=0x5C stable for all 4 cycles; IDLE the cycle after MRespAccept=1.
- RD 0xFE → SData=0xA5. RD 0xFF with status_in=0x3C → SData=0x3C.
- WR 0x20 (unmapped, NUM_REGS=8) and MCmd=3'b101, with the macro → ERR each time and no register change. Without the macro → DVA each time and no register change.
- Back-to-back RD/WR with MRespAccept tied high → one transaction every 2 cycles, with SCmdAccept=0 on every RESP cycle.
- rst_n pulled low while in RESP after a WR to 0x01 → SResp=NULL immediately and reg_q[15:8]=RESET_VAL.
